// File: rtl/store_unit.sv
// store_unit: accepts one store, computes rs1 + sext(imm), checks alignment and
// funct3, then drives a single-beat write with lane-replicated data and strobes.
module store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [11:0] imm,
    input  logic [2:0]  funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    output logic        done,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned ADDR_W = 32;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         ea_lo;
    logic [1:0]         ea_lo_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        wdata_d;
    logic [3:0]         wstrb_d;
    logic [ADDR_W-1:0]  err_addr_d;

    logic [ADDR_W-1:0]  ea_c;
    logic               fault_c;
    logic [31:0]        wdata_c;
    logic [3:0]         wstrb_c;
    logic               timeout_c;

    // Accept only from IDLE, and never while reset is asserted.
    assign st_ready = (state == S_IDLE) && !rst;

    // Effective address, fault decode and lane/strobe formatting of the offered store.
    always_comb begin
        ea_c    = rs1_data + {{20{imm[11]}}, imm};
        fault_c = 1'b0;
        wdata_c = rs2_data;
        wstrb_c = 4'b1111;
        case (funct3)
            3'b000: begin
                wdata_c = {4{rs2_data[7:0]}};
                wstrb_c = 4'b0001 << ea_c[1:0];
            end
            3'b001: begin
                fault_c = ea_c[0];
                wdata_c = {2{rs2_data[15:0]}};
                wstrb_c = ea_c[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                fault_c = |ea_c[1:0];
            end
            default: begin
                fault_c = 1'b1;
            end
        endcase
    end

    // Stall limit reached on the current cycle of REQ.
    assign timeout_c = TO_EN && (cnt == TO_LAST);

    // Next-state and next-value logic; every register holds by default.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ea_lo_d    = ea_lo;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        wstrb_d    = mem_wstrb;
        err_addr_d = err_addr;
        case (state)
            S_IDLE: begin
                if (st_valid) begin
                    if (fault_c) begin
                        err_addr_d = ea_c;
                        state_d    = S_FAULT;
                    end else begin
                        addr_d  = {ea_c[31:2], 2'b00};
                        wdata_d = wdata_c;
                        wstrb_d = wstrb_c;
                        ea_lo_d = ea_c[1:0];
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                end else if (timeout_c) begin
                    err_addr_d = mem_addr | {30'd0, ea_lo};
                    state_d    = S_FAULT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ea_lo     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            err_addr  <= '0;
            mem_req   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            ea_lo     <= ea_lo_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wstrb <= wstrb_d;
            err_addr  <= err_addr_d;
            mem_req   <= (state_d == S_REQ);
            done      <= (state_d == S_RESP);
            err       <= (state_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: instance 0 uses the default timeout, instance 1 a 4-cycle timeout.
module tb_store_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic        st_valid  [2];
    logic        mem_ready [2];
    logic        st_ready  [2];
    logic        mem_req   [2];
    logic        done      [2];
    logic        err       [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] err_addr  [2];
    logic [3:0]  mem_wstrb [2];

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    store_unit u0 (
        .clk(clk), .rst(rst), .st_valid(st_valid[0]), .st_ready(st_ready[0]),
        .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .funct3(f3),
        .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]), .done(done[0]),
        .err(err[0]), .err_addr(err_addr[0])
    );

    store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .st_valid(st_valid[1]), .st_ready(st_ready[1]),
        .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .funct3(f3),
        .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]), .done(done[1]),
        .err(err[1]), .err_addr(err_addr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one store to instance s; returns just after the accepting edge.
    task automatic issue(input int s, input logic [31:0] a, input logic [31:0] d,
                         input logic [11:0] i, input logic [2:0] f);
        int n;
        n = 0;
        @(negedge clk);
        while (st_ready[s] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_wait: st_ready got %b exp 1", st_ready[s]);
        end
        rs1 = a; rs2 = d; imm = i; f3 = f;
        st_valid[s] = 1'b1;
        @(posedge clk);
        #1 st_valid[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (st_ready[0] !== 1'b0) begin miscompares++; $display("FAIL rst_st_ready: got %b exp 0", st_ready[0]); end
        vectors++; if (mem_req[0] !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b exp 0", mem_req[0]); end
        vectors++; if (done[0] !== 1'b0 || err[0] !== 1'b0) begin miscompares++; $display("FAIL rst_done_err: got %b%b exp 00", done[0], err[0]); end
        vectors++; if (mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0) begin miscompares++; $display("FAIL rst_addr_data: got %h %h exp 0 0", mem_addr[0], mem_wdata[0]); end
        vectors++; if (mem_wstrb[0] !== 4'h0 || err_addr[0] !== 32'h0) begin miscompares++; $display("FAIL rst_strb_erraddr: got %h %h exp 0 0", mem_wstrb[0], err_addr[0]); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (st_ready[0] !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b exp 1", st_ready[0]); end
    endtask

    // Common tail for a store granted on its first REQ cycle.
    task automatic test_simple(input string nm, input logic [31:0] a, input logic [31:0] d,
                               input logic [11:0] i, input logic [2:0] f, input exp_t e);
        exp_t g;
        mem_ready[0] = 1'b1;
        sb.push_back(e);
        issue(0, a, d, i, f);
        @(negedge clk);
        vectors++; if (mem_req[0] !== 1'b1) begin miscompares++; $display("FAIL %s_req: got %b exp 1", nm, mem_req[0]); end
        g = sb.pop_front();
        vectors++; if (mem_addr[0] !== g.addr) begin miscompares++; $display("FAIL %s_addr: got %h exp %h", nm, mem_addr[0], g.addr); end
        vectors++; if (mem_wdata[0] !== g.wdata) begin miscompares++; $display("FAIL %s_wdata: got %h exp %h", nm, mem_wdata[0], g.wdata); end
        vectors++; if (mem_wstrb[0] !== g.wstrb) begin miscompares++; $display("FAIL %s_wstrb: got %b exp %b", nm, mem_wstrb[0], g.wstrb); end
        vectors++; if (done[0] !== 1'b0) begin miscompares++; $display("FAIL %s_early_done: got %b exp 0", nm, done[0]); end
        @(negedge clk);
        vectors++; if (done[0] !== 1'b1 || mem_req[0] !== 1'b0 || err[0] !== 1'b0) begin miscompares++; $display("FAIL %s_done: got done=%b req=%b err=%b exp 1 0 0", nm, done[0], mem_req[0], err[0]); end
        vectors++; if (st_ready[0] !== 1'b0) begin miscompares++; $display("FAIL %s_ready_in_resp: got %b exp 0", nm, st_ready[0]); end
        @(negedge clk);
        vectors++; if (st_ready[0] !== 1'b1 || done[0] !== 1'b0) begin miscompares++; $display("FAIL %s_ready_after: got rdy=%b done=%b exp 1 0", nm, st_ready[0], done[0]); end
    endtask

    task automatic test_sw_aligned();
        test_simple("sw", 32'h1000, 32'hDEADBEEF, 12'h004, 3'b010, '{32'h1004, 32'hDEADBEEF, 4'b1111});
    endtask

    task automatic test_sb_negative();
        test_simple("sb", 32'h2004, 32'h000000A5, 12'hFFF, 3'b000, '{32'h2000, 32'hA5A5A5A5, 4'b1000});
    endtask

    // Faulting stores: err at T+1, no request, err_addr is the effective address.
    task automatic test_faults();
        logic [2:0]  fs [3];
        logic [11:0] is [3];
        logic [31:0] ex [3];
        fs[0] = 3'b001; is[0] = 12'h001; ex[0] = 32'h3001;
        fs[1] = 3'b011; is[1] = 12'h001; ex[1] = 32'h3001;
        fs[2] = 3'b100; is[2] = 12'h000; ex[2] = 32'h3000;
        mem_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(0, 32'h3000, 32'h11223344, is[k], fs[k]);
            @(negedge clk);
            vectors++; if (err[0] !== 1'b1 || done[0] !== 1'b0) begin miscompares++; $display("FAIL fault%0d_err: got err=%b done=%b exp 1 0", k, err[0], done[0]); end
            vectors++; if (err_addr[0] !== ex[k]) begin miscompares++; $display("FAIL fault%0d_err_addr: got %h exp %h", k, err_addr[0], ex[k]); end
            vectors++; if (mem_req[0] !== 1'b0) begin miscompares++; $display("FAIL fault%0d_req: got %b exp 0", k, mem_req[0]); end
            @(negedge clk);
            vectors++; if (err[0] !== 1'b0 || done[0] !== 1'b0 || mem_req[0] !== 1'b0) begin miscompares++; $display("FAIL fault%0d_after: got err=%b done=%b req=%b exp 0 0 0", k, err[0], done[0], mem_req[0]); end
        end
    endtask

    // SH held off five cycles: request and payload stay stable until the grant.
    task automatic test_stall_grant();
        exp_t g;
        mem_ready[0] = 1'b0;
        sb.push_back('{32'h4000, 32'hABCDABCD, 4'b1100});
        issue(0, 32'h4000, 32'h1234ABCD, 12'h002, 3'b001);
        g = sb.pop_front();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++; if (mem_req[0] !== 1'b1 || done[0] !== 1'b0 || err[0] !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d: got req=%b done=%b err=%b exp 1 0 0", k, mem_req[0], done[0], err[0]); end
            vectors++; if (mem_addr[0] !== g.addr || mem_wdata[0] !== g.wdata || mem_wstrb[0] !== g.wstrb) begin miscompares++; $display("FAIL stall_payload%0d: got %h %h %b exp %h %h %b", k, mem_addr[0], mem_wdata[0], mem_wstrb[0], g.addr, g.wdata, g.wstrb); end
            if (k == 5) mem_ready[0] = 1'b1;
        end
        @(negedge clk);
        vectors++; if (done[0] !== 1'b1 || mem_req[0] !== 1'b0) begin miscompares++; $display("FAIL stall_done: got done=%b req=%b exp 1 0", done[0], mem_req[0]); end
    endtask

    // Four-cycle timeout on instance 1, including the ready-on-last-cycle race.
    task automatic test_timeout();
        logic [31:0] a [3];
        logic [2:0]  f [3];
        bit          late [3];
        a[0] = 32'h5000; f[0] = 3'b010; late[0] = 1'b0;
        a[1] = 32'h5003; f[1] = 3'b000; late[1] = 1'b0;
        a[2] = 32'h5000; f[2] = 3'b010; late[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            mem_ready[1] = 1'b0;
            issue(1, a[t], 32'hCAFEF00D, 12'h000, f[t]);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                vectors++; if (mem_req[1] !== 1'b1 || err[1] !== 1'b0) begin miscompares++; $display("FAIL to%0d_req%0d: got req=%b err=%b exp 1 0", t, k, mem_req[1], err[1]); end
                if (k == 3 && late[t]) mem_ready[1] = 1'b1;
            end
            @(negedge clk);
            vectors++; if (mem_req[1] !== 1'b0) begin miscompares++; $display("FAIL to%0d_req_drop: got %b exp 0", t, mem_req[1]); end
            if (late[t]) begin
                vectors++; if (done[1] !== 1'b1 || err[1] !== 1'b0) begin miscompares++; $display("FAIL to%0d_late_grant: got done=%b err=%b exp 1 0", t, done[1], err[1]); end
            end else begin
                vectors++; if (err[1] !== 1'b1 || done[1] !== 1'b0) begin miscompares++; $display("FAIL to%0d_err: got err=%b done=%b exp 1 0", t, err[1], done[1]); end
                vectors++; if (err_addr[1] !== a[t]) begin miscompares++; $display("FAIL to%0d_err_addr: got %h exp %h", t, err_addr[1], a[t]); end
            end
            @(negedge clk);
            vectors++; if (err[1] !== 1'b0 || done[1] !== 1'b0) begin miscompares++; $display("FAIL to%0d_pulse_len: got err=%b done=%b exp 0 0", t, err[1], done[1]); end
        end
        mem_ready[1] = 1'b0;
    endtask

    // Reset while a request is outstanding drops it with no completion.
    task automatic test_reset_mid_req();
        exp_t g;
        mem_ready[0] = 1'b0;
        sb.push_back('{32'h6000, 32'h55AA55AA, 4'b1111});
        issue(0, 32'h6000, 32'h55AA55AA, 12'h000, 3'b010);
        @(negedge clk);
        g = sb.pop_front();
        vectors++; if (mem_req[0] !== 1'b1 || mem_addr[0] !== g.addr) begin miscompares++; $display("FAIL rmid_req: got req=%b addr=%h exp 1 %h", mem_req[0], mem_addr[0], g.addr); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (mem_req[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_outputs: got req=%b done=%b err=%b exp 0 0 0", mem_req[0], done[0], err[0]); end
        vectors++; if (err_addr[0] !== 32'h0 || st_ready[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_erraddr_ready: got %h %b exp 0 0", err_addr[0], st_ready[0]); end
        rst = 1'b0;
        mem_ready[0] = 1'b1;
        @(negedge clk);
        vectors++; if (st_ready[0] !== 1'b1 || done[0] !== 1'b0 || err[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_after: got rdy=%b done=%b err=%b exp 1 0 0", st_ready[0], done[0], err[0]); end
    endtask

    // Random stream of stores issued as fast as the unit accepts them.
    task automatic test_back_to_back();
        logic [31:0] a, d, ea;
        logic [11:0] i;
        logic [2:0]  f;
        exp_t        e, g;
        bit          bad;
        mem_ready[0] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            a  = $urandom;
            d  = $urandom;
            i  = 12'($urandom_range(0, 4095));
            f  = 3'($urandom_range(0, 3));
            ea = a + {{20{i[11]}}, i};
            bad = 1'b0;
            e.addr = {ea[31:2], 2'b00};
            case (f)
                3'b000: begin
                    e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
                    case (ea[1:0])
                        2'd0: e.wstrb = 4'b0001;
                        2'd1: e.wstrb = 4'b0010;
                        2'd2: e.wstrb = 4'b0100;
                        default: e.wstrb = 4'b1000;
                    endcase
                end
                3'b001: begin
                    e.wdata = {d[15:0], d[15:0]};
                    e.wstrb = (ea[1:0] == 2'd2) ? 4'b1100 : 4'b0011;
                    bad = (ea[0] == 1'b1);
                end
                3'b010: begin
                    e.wdata = d;
                    e.wstrb = 4'b1111;
                    bad = (ea[1:0] != 2'd0);
                end
                default: begin
                    e.wdata = d;
                    e.wstrb = 4'b1111;
                    bad = 1'b1;
                end
            endcase
            if (!bad) sb.push_back(e);
            issue(0, a, d, i, f);
            @(negedge clk);
            if (bad) begin
                vectors++; if (err[0] !== 1'b1 || err_addr[0] !== ea || mem_req[0] !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_fault: got err=%b ea=%h req=%b exp 1 %h 0", n, err[0], err_addr[0], mem_req[0], ea); end
            end else begin
                g = sb.pop_front();
                vectors++; if (mem_req[0] !== 1'b1 || mem_addr[0] !== g.addr || mem_wdata[0] !== g.wdata || mem_wstrb[0] !== g.wstrb) begin miscompares++; $display("FAIL b2b%0d_write: got req=%b %h %h %b exp 1 %h %h %b", n, mem_req[0], mem_addr[0], mem_wdata[0], mem_wstrb[0], g.addr, g.wdata, g.wstrb); end
                @(negedge clk);
                vectors++; if (done[0] !== 1'b1 || err[0] !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_done: got done=%b err=%b exp 1 0", n, done[0], err[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rs1 = '0; rs2 = '0; imm = '0; f3 = '0;
        st_valid[0] = 1'b0; st_valid[1] = 1'b0;
        mem_ready[0] = 1'b0; mem_ready[1] = 1'b0;
        test_reset();
        test_sw_aligned();
        test_sb_negative();
        test_faults();
        test_stall_grant();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side companion to the core's load path. Accepts one store instruction's operands, computes the effective address as rs1 + sign-extended imm, and checks alignment and funct3.
- Drives a single-beat request/ready write port to data memory with byte lanes replicated and byte strobes set.
- Reports completion (done) or fault (err) with a one-cycle pulse. Sits between the execute stage and the data-memory port.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay high without mem_ready before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
st_valid  input  1  store operands valid
st_ready  output  1  unit can accept a store; high only in IDLE and not in reset
rs1_data  input  32  base address register value
rs2_data  input  32  store data register value
imm  input  12  store offset, two's complement
funct3  input  3  000 SB, 001 SH, 010 SW; all others unsupported
mem_req  output  1  write request to data memory
mem_addr  output  32  word-aligned write address, bits [1:0] always 0
mem_wdata  output  32  write data, lane-replicated
mem_wstrb  output  4  byte-enable strobes
mem_ready  input  1  memory accepts the write in the current cycle
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: store faulted, no memory write performed
err_addr  output  32  effective address of the last faulting store

Behaviour:
- Reset (rst high at an edge) forces:
  - state to IDLE;
  - mem_req, done, err, mem_wstrb to 0;
  - mem_addr, mem_wdata, err_addr, timeout counter to 0;
  - st_ready to 0 while rst is high.
- States: IDLE, REQ, RESP, FAULT.
- Accept condition: st_valid && st_ready in IDLE.
- Effective address: ea = rs1_data + sext(imm), computed mod 2^32 with no overflow flag.
- Fault conditions:
  - funct3 not in {000, 001, 010};
  - SH with ea[0] = 1;
  - SW with ea[1:0] != 00.
- On a fault at accept: err_addr <= ea, go to FAULT. No mem_req is ever raised for a faulting store.
- On a valid accept, go to REQ with:
  - mem_addr <= {ea[31:2], 2'b00};
  - SB: mem_wdata <= {4{rs2_data[7:0]}}, mem_wstrb <= 0001 << ea[1:0];
  - SH: mem_wdata <= {2{rs2_data[15:0]}}, mem_wstrb <= 0011 << {ea[1], 1'b0};
  - SW: mem_wdata <= rs2_data, mem_wstrb <= 1111;
  - timeout counter cleared.
- REQ:
  - mem_req = 1. mem_addr, mem_wdata and mem_wstrb are held stable until the handshake completes.
  - If mem_ready = 1: the write occurs this cycle. Next edge goes to RESP and drops mem_req.
  - Else the counter increments. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with mem_ready still low: next edge goes to FAULT, drops mem_req, and sets err_addr <= mem_addr | ea[1:0] (registered ea).
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins and the store completes.
- RESP: done = 1 for exactly one cycle, st_ready = 0, then IDLE.
- FAULT: err = 1 for exactly one cycle, st_ready = 0, then IDLE.
- done and err are never high together.
- mem_addr, mem_wdata and mem_wstrb hold their last values outside REQ. Consumers qualify them with mem_req.
- Latency for an accept at cycle T:
  - mem_req high at T+1;
  - with mem_ready at T+1, done at T+2;
  - st_ready high at T+3.
  - Minimum 3 cycles per store.
  - A fault at accept gives err at T+1.
- Reset mid-operation: the transaction is dropped silently. mem_req is 0 after the edge, and no done or err is issued.
- st_valid while st_ready = 0 is ignored. The upstream stage holds operands until the handshake.

Test Plan:
1. SW aligned: rs1 = 0x1000, imm = 0x004, rs2 = 0xDEADBEEF, mem_ready high -> mem_req at T+1 with addr 0x1004, wdata 0xDEADBEEF, wstrb 1111; done at T+2; st_ready at T+3.
2. SB with negative imm: rs1 = 0x2004, imm = 0xFFF (-1), rs2 = 0x000000A5 -> addr 0x2000, wstrb 1000, wdata 0xA5A5A5A5, done pulse.
3. SH misaligned: rs1 = 0x3000, imm = 0x001, funct3 = 001 -> err at T+1, err_addr 0x3001, mem_req never asserted, no done. Repeat with funct3 = 011 -> err, err_addr 0x3001.
4. Stall then grant: SH to 0x4002, mem_ready low 5 cycles then high -> mem_req high 6 cycles with stable addr 0x4000, wstrb 1100, wdata {2{rs2[15:0]}}; done the cycle after grant.
5. Timeout: TIMEOUT_CYCLES = 4, SW to 0x5000, mem_ready held low -> mem_req high exactly 4 cycles, then err pulse, err_addr 0x5000, no done. Repeat with mem_ready rising in the 4th cycle -> done, no err.
6. Reset mid-REQ: assert rst for one cycle while mem_req is high -> mem_req 0, done 0, err 0, err_addr 0 after the edge; st_ready 1 the cycle after rst deasserts.
